vid_rdbuf: RTL and testbench
============================

VID_RDBUF -- requirements
Module: vid_rdbuf

Interface
REQ-001 Parameter: AW, 6, log2 of buffer depth in 32-bit dwords (depth 64).
REQ-002 Parameter: BURST_LEN, 8, dwords returned per SDRAM read request.
REQ-003 Ports (name, direction, width, meaning):
- mem_clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- mem_rd_data_valid, in, 1, SDRAM read dword present this cycle.
- mem_rd_data, in, 32, SDRAM read dword.
- flush, in, 1, synchronous frame-start clear.
- pix_rd, in, 1, scanout pops one dword.
- pix_data, out, 32, popped dword.
- pix_valid, out, 1, pix_data updated this cycle.
- fifo_level, out, 2, fill quartile, feeds the reader's fifo_level.
- burst_done, out, 1, one-cycle pulse per BURST_LEN words received.
- overflow, out, 1, sticky: write dropped while full.
- underflow, out, 1, sticky: pop while empty.
REQ-004 Clock and reset: reset is synchronous, active-high; the clock is mem_clk.

Function
REQ-005 Storage: single-clock circular buffer, 2^AW x 32; write pointer wp and read pointer rp, each AW bits, wrapping 63->0.
REQ-006 Occupancy counter usedw: AW+1 bits, range 0..64; empty = (usedw==0); full = (usedw==64).
REQ-007 Write: mem_rd_data_valid & ~full -> store at wp, wp+1.
REQ-008 Write with full & ~pix_rd -> word dropped; overflow set next cycle.
REQ-009 Read: pix_rd & ~empty -> pix_data <= mem[rp] at next edge; pix_valid=1 that cycle; rp+1. Latency 1 cycle.
REQ-010 pix_rd & empty -> pix_valid=0; pix_data holds; underflow set. Empty is evaluated before a same-cycle write, so a word written this cycle is never readable this cycle.
REQ-011 Simultaneous accepted read and write: usedw unchanged.
REQ-012 Full & pix_rd & mem_rd_data_valid: both accepted; usedw stays 64; no overflow.
REQ-013 usedw changes: +1 on write only, -1 on read only, otherwise unchanged. It never exceeds 64 and never goes below 0.
REQ-014 fifo_level is registered: 3 if usedw>=48, otherwise usedw[5:4]. It therefore reads 0 for 0..15, 1 for 16..31 and 2 for 32..47.
REQ-015 fifo_level lags usedw by 1 cycle.
REQ-016 Burst counter: 3 bits (log2 BURST_LEN). It increments on every mem_rd_data_valid, whether accepted or dropped.
REQ-017 burst_done pulses high for 1 cycle, the cycle after the counter wraps from 7 to 0.
REQ-018 flush: next edge sets wp=rp=0, usedw=0, burst counter=0 and pix_valid=0.
REQ-019 flush overrides same-cycle valid and pix_rd: the word is discarded and no flag is set.
REQ-020 overflow and underflow are cleared only by reset; flush does not clear them.
REQ-021 Buffer RAM contents are not reset. pix_data is never driven from unwritten locations except through the underflow hold behaviour.

Reset
REQ-022 Reset takes priority over flush and all traffic.
REQ-023 Reset values: wp=rp=0, usedw=0, burst counter=0, pix_data=0, pix_valid=0, fifo_level=0, burst_done=0, overflow=0, underflow=0.
REQ-024 Reset asserted mid-burst: partial burst discarded; counter restarts at 0 after release.
REQ-025 Outputs hold their reset values for the whole reset assertion and for the first edge after release.

Verification
REQ-026 Reset, then one burst of 8 dwords 0x100..0x107 -> burst_done single pulse; usedw=8; fifo_level=0; 8 pops return 0x100..0x107 in order, each with pix_valid exactly 1 cycle after pix_rd.
REQ-027 Write 64 dwords, then 1 more with no pop -> full; 65th word dropped; overflow=1; fifo_level=3; subsequent pops return the first 64 words only.
REQ-028 Full plus simultaneous valid and pix_rd for 10 cycles -> usedw stays 64; overflow stays 0; data order preserved across pointer wrap.
REQ-029 Pop on empty, with a same-cycle write of 0xDEAD -> pix_valid=0; underflow=1; next pop returns 0xDEAD.
REQ-030 Fill 40 words, assert flush with a same-cycle valid -> usedw=0; fifo_level=0 one cycle later; burst counter restarts, so burst_done fires after exactly 8 new words; sticky flags unchanged.
REQ-031 Assert reset after 5 words of a burst -> all outputs at reset values; a following full burst yields exactly one burst_done.

Source files
------------

// File: rtl/vid_rdbuf.sv
// vid_rdbuf: single-clock SDRAM-to-scanout dword buffer.
// Circular 2^AW x 32 store with quartile level, burst pulse and sticky error flags.
module vid_rdbuf #(
    parameter int AW        = 6,
    parameter int BURST_LEN = 8
) (
    input  logic        mem_clk,
    input  logic        reset,
    input  logic        mem_rd_data_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        flush,
    input  logic        pix_rd,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic [1:0]  fifo_level,
    output logic        burst_done,
    output logic        overflow,
    output logic        underflow
);

    localparam int DEPTH = 1 << AW;
    localparam int BW    = $clog2(BURST_LEN);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   Q3_CNT   = (AW + 1)'(3 * DEPTH / 4);
    localparam logic [BW-1:0] BLAST    = BW'(BURST_LEN - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   usedw;
    logic [BW-1:0] bcnt;

    logic       empty;
    logic       full;
    logic       rd_ok;
    logic       wr_ok;
    logic       wr_drop;
    logic       rd_miss;
    logic [1:0] level;

    // Accept/drop decisions use occupancy before this cycle's traffic.
    always_comb begin
        empty   = (usedw == '0);
        full    = (usedw == FULL_CNT);
        rd_ok   = pix_rd & ~empty & ~flush & ~reset;
        // A write into a full buffer is still taken when a pop frees a slot.
        wr_ok   = mem_rd_data_valid & (~full | rd_ok) & ~flush & ~reset;
        wr_drop = mem_rd_data_valid & full & ~rd_ok & ~flush;
        rd_miss = pix_rd & empty & ~flush;
        level   = (usedw >= Q3_CNT) ? 2'd3 : usedw[AW-1:AW-2];
    end

    // Buffer RAM: written only, never cleared.
    always_ff @(posedge mem_clk) begin
        if (wr_ok) begin
            mem[wp] <= mem_rd_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge mem_clk) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            usedw <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + AW'(1);
            end
            if (rd_ok) begin
                rp <= rp + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   usedw <= usedw + (AW + 1)'(1);
                2'b01:   usedw <= usedw - (AW + 1)'(1);
                default: usedw <= usedw;
            endcase
        end
    end

    // Pop path: data holds on a miss, valid marks a fresh word.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else if (flush) begin
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= rd_ok;
            if (rd_ok) begin
                pix_data <= mem[rp];
            end
        end
    end

    // Burst counter counts every arriving dword, kept or dropped.
    always_ff @(posedge mem_clk) begin
        if (reset || flush) begin
            bcnt       <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (mem_rd_data_valid) begin
                bcnt <= bcnt + BW'(1);
                if (bcnt == BLAST) begin
                    burst_done <= 1'b1;
                end
            end
        end
    end

    // Sticky error flags survive flush.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (rd_miss) begin
                underflow <= 1'b1;
            end
        end
    end

    // Quartile level, one cycle behind occupancy.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            fifo_level <= 2'd0;
        end else begin
            fifo_level <= level;
        end
    end

endmodule

// File: tb/tb_vid_rdbuf.sv
// tb_vid_rdbuf: directed self-checking bench for vid_rdbuf.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_vid_rdbuf;

    logic        mem_clk;
    logic        reset;
    logic        mem_rd_data_valid;
    logic [31:0] mem_rd_data;
    logic        flush;
    logic        pix_rd;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic [1:0]  fifo_level;
    logic        burst_done;
    logic        overflow;
    logic        underflow;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;

    vid_rdbuf #(.AW(6), .BURST_LEN(8)) dut (
        .mem_clk           (mem_clk),
        .reset             (reset),
        .mem_rd_data_valid (mem_rd_data_valid),
        .mem_rd_data       (mem_rd_data),
        .flush             (flush),
        .pix_rd            (pix_rd),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .fifo_level        (fifo_level),
        .burst_done        (burst_done),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pix_data"}, pix_data, 32'h0);
        chk({tag, " pix_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, " fifo_level"}, {30'd0, fifo_level}, 32'd0);
        chk({tag, " burst_done"}, {31'd0, burst_done}, 32'd0);
        chk({tag, " overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, " underflow"}, {31'd0, underflow}, 32'd0);
        chk({tag, " usedw"}, 32'(dut.usedw), 32'd0);
    endtask

    task automatic push(input logic [31:0] d);
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = d;
        step();
        mem_rd_data_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        flush             = 1'b0;
        pix_rd            = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();
        chk_reset_vals("post_release");

        // one burst, then drain it
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(i));
            chk("b1 burst_done", {31'd0, burst_done}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("b1 burst_done off", {31'd0, burst_done}, 32'd0);
        chk("b1 usedw", 32'(dut.usedw), 32'd8);
        chk("b1 level", {30'd0, fifo_level}, 32'd0);
        pix_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("b1 pix_valid", {31'd0, pix_valid}, 32'd1);
            chk("b1 pix_data", pix_data, 32'h100 + 32'(i));
        end
        pix_rd = 1'b0;
        step();
        chk("b1 valid off", {31'd0, pix_valid}, 32'd0);
        chk("b1 empty", 32'(dut.usedw), 32'd0);
        chk("b1 underflow", {31'd0, underflow}, 32'd0);

        // fill, then 10 cycles of push+pop while full
        for (int i = 0; i < 64; i++) begin
            push(32'h2000 + 32'(i));
        end
        chk("full usedw", 32'(dut.usedw), 32'd64);
        mem_rd_data_valid = 1'b1;
        pix_rd            = 1'b1;
        for (int j = 0; j < 10; j++) begin
            mem_rd_data = 32'h3000 + 32'(j);
            step();
            chk("rw pix_data", pix_data, 32'h2000 + 32'(j));
            chk("rw usedw", 32'(dut.usedw), 32'd64);
        end
        mem_rd_data_valid = 1'b0;
        chk("rw overflow", {31'd0, overflow}, 32'd0);
        chk("rw level", {30'd0, fifo_level}, 32'd3);
        for (int i = 0; i < 64; i++) begin
            step();
            chk("wrap pix_data", pix_data,
                (i < 54) ? 32'h200A + 32'(i) : 32'h3000 + 32'(i - 54));
        end
        pix_rd = 1'b0;
        step();
        chk("wrap empty", 32'(dut.usedw), 32'd0);
        chk("wrap underflow", {31'd0, underflow}, 32'd0);

        // overflow: 64 words plus one dropped
        for (int i = 0; i < 64; i++) begin
            push(32'h4000 + 32'(i));
        end
        chk("ovf pre", {31'd0, overflow}, 32'd0);
        push(32'h0BAD);
        chk("ovf set", {31'd0, overflow}, 32'd1);
        chk("ovf usedw", 32'(dut.usedw), 32'd64);
        step();
        chk("ovf level", {30'd0, fifo_level}, 32'd3);
        pix_rd = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("ovf pix_data", pix_data, 32'h4000 + 32'(i));
        end
        pix_rd = 1'b0;
        step();
        chk("ovf empty", 32'(dut.usedw), 32'd0);
        chk("ovf underflow", {31'd0, underflow}, 32'd0);

        // pop on empty with same-cycle write
        pix_rd            = 1'b1;
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = 32'hDEAD;
        step();
        mem_rd_data_valid = 1'b0;
        chk("uf pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("uf pix_data hold", pix_data, 32'h403F);
        chk("uf underflow", {31'd0, underflow}, 32'd1);
        step();
        pix_rd = 1'b0;
        chk("uf next valid", {31'd0, pix_valid}, 32'd1);
        chk("uf next data", pix_data, 32'hDEAD);

        // flush with same-cycle valid
        for (int i = 0; i < 40; i++) begin
            push(32'h5000 + 32'(i));
        end
        flush             = 1'b1;
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = 32'h0F00;
        step();
        flush             = 1'b0;
        mem_rd_data_valid = 1'b0;
        chk("fl usedw", 32'(dut.usedw), 32'd0);
        chk("fl pix_valid", {31'd0, pix_valid}, 32'd0);
        step();
        chk("fl level", {30'd0, fifo_level}, 32'd0);
        chk("fl overflow", {31'd0, overflow}, 32'd1);
        chk("fl underflow", {31'd0, underflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            push(32'h6000 + 32'(i));
            chk("fl burst_done", {31'd0, burst_done}, (i == 7) ? 32'd1 : 32'd0);
        end
        pix_rd = 1'b1;
        step();
        pix_rd = 1'b0;
        chk("fl first word", pix_data, 32'h6000);

        // reset mid-burst
        for (int i = 0; i < 5; i++) begin
            push(32'h7000 + 32'(i));
        end
        reset = 1'b1;
        step();
        chk_reset_vals("mid reset");
        step();
        reset = 1'b0;
        step();
        chk_reset_vals("mid release");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            push(32'h8000 + 32'(i));
            if (burst_done) pulses++;
            chk("rb burst_done", {31'd0, burst_done}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        if (burst_done) pulses++;
        chk("rb pulses", 32'(pulses), 32'd1);
        chk("rb usedw", 32'(dut.usedw), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
